// File: rtl/combo_lock_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : combo_lock_pkg
//  Description : Shared types and width helpers for the combination lock.
//  Revision    : 1.0 - initial release
// ============================================================================
package combo_lock_pkg;

    // Top-level controller states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OPEN    = 2'd1,
        ERROR   = 2'd2,
        LOCKOUT = 2'd3
    } state_t;

    // Down-timer width: enough bits to hold the largest reload (max-1)
    function automatic int timer_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

    // Entry-index width, never narrower than one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/combo_lock_enter_sync.sv
`default_nettype none
// ============================================================================
//  Module      : combo_lock_enter_sync
//  Description : Two-flop synchroniser for the raw enter button followed by a
//                rising-edge detector producing a registered one-cycle press.
//  Revision    : 1.0 - initial release
// ============================================================================
module combo_lock_enter_sync
    import combo_lock_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic enter,
    output logic press
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic r_press;

    // Synchronise enter, remember the previous level and register the edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_sync1 <= enter;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_press <= r_sync2 & ~r_prev;
        end
    end

    assign press = r_press;

endmodule
`default_nettype wire

// File: rtl/combo_lock.sv
`default_nettype none
// ============================================================================
//  Module      : combo_lock
//  Description : Parametrised combination-lock controller. Collects CODE_LEN
//                entries (one per debounced press), opens on a full match,
//                blinks an error otherwise and locks out after MAX_FAIL
//                consecutive failures.
//  Revision    : 1.0 - initial release
// ============================================================================
module combo_lock
    import combo_lock_pkg::*;
#(
    parameter int                         KEY_W       = 2,
    parameter int                         CODE_LEN    = 2,
    parameter logic [CODE_LEN*KEY_W-1:0]  CODE        = 4'b10_01,
    parameter int                         MAX_FAIL    = 3,
    parameter int                         OPEN_CYCLES = 16,
    parameter int                         LOCK_CYCLES = 64,
    parameter int                         BLINK_HALF  = 4
)(
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             enter,
    input  logic [KEY_W-1:0]                 key,
    output logic                             open,
    output logic                             error,
    output logic                             led,
    output logic                             locked,
    output logic [$clog2(MAX_FAIL+1)-1:0]    fail_cnt
);

    localparam int c_idx_w   = idx_width(CODE_LEN);
    localparam int c_timer_w = timer_width(OPEN_CYCLES, LOCK_CYCLES, BLINK_HALF);
    localparam int c_fail_w  = $clog2(MAX_FAIL + 1);

    localparam logic [c_idx_w-1:0]   c_last_idx   = c_idx_w'(CODE_LEN - 1);
    localparam logic [c_timer_w-1:0] c_open_load  = c_timer_w'(OPEN_CYCLES - 1);
    localparam logic [c_timer_w-1:0] c_lock_load  = c_timer_w'(LOCK_CYCLES - 1);
    localparam logic [c_timer_w-1:0] c_blink_load = c_timer_w'(BLINK_HALF - 1);
    localparam logic [c_fail_w-1:0]  c_fail_max   = c_fail_w'(MAX_FAIL);

    // Registered state
    state_t                 r_state;
    logic [c_idx_w-1:0]     r_idx;
    logic                   r_match;
    logic [c_timer_w-1:0]   r_timer;
    logic [c_timer_w-1:0]   r_blink;
    logic [c_fail_w-1:0]    r_fail;
    logic                   r_open;
    logic                   r_error;
    logic                   r_led;
    logic                   r_locked;

    // Next-state values
    state_t                 w_state_nxt;
    logic [c_idx_w-1:0]     w_idx_nxt;
    logic                   w_match_nxt;
    logic [c_timer_w-1:0]   w_timer_nxt;
    logic [c_timer_w-1:0]   w_blink_nxt;
    logic [c_fail_w-1:0]    w_fail_nxt;
    logic                   w_led_nxt;
    logic                   w_match_all;
    logic                   w_press;

    // Secret code split into per-entry words, entry 0 entered first
    logic [KEY_W-1:0] w_code_entry [CODE_LEN];

    for (genvar gi = 0; gi < CODE_LEN; gi++) begin : g_code_entry
        assign w_code_entry[gi] = CODE[gi*KEY_W +: KEY_W];
    end

    combo_lock_enter_sync u_enter_sync (
        .clk   (clk),
        .rst   (rst),
        .enter (enter),
        .press (w_press)
    );

    // Next-state logic: entry collection, timers, blink and fail counting
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_match_nxt = r_match;
        w_timer_nxt = r_timer;
        w_blink_nxt = r_blink;
        w_fail_nxt  = r_fail;
        w_led_nxt   = r_led;
        w_match_all = r_match & (key == w_code_entry[r_idx]);

        case (r_state)
            IDLE: begin
                if (w_press) begin
                    if (r_idx == c_last_idx) begin
                        // Last entry: judge the whole attempt, restart collection
                        w_idx_nxt   = '0;
                        w_match_nxt = 1'b1;
                        if (w_match_all) begin
                            w_state_nxt = OPEN;
                            w_timer_nxt = c_open_load;
                            w_fail_nxt  = '0;
                        end else begin
                            w_state_nxt = ERROR;
                            w_blink_nxt = c_blink_load;
                            w_led_nxt   = 1'b1;
                            w_fail_nxt  = (r_fail == c_fail_max) ? c_fail_max
                                                                 : r_fail + 1'b1;
                        end
                    end else begin
                        // Keep collecting; a wrong entry is only remembered
                        w_idx_nxt   = r_idx + 1'b1;
                        w_match_nxt = w_match_all;
                    end
                end
            end

            OPEN: begin
                // A press closes the lock early and is not treated as an entry
                if (w_press || (r_timer == '0)) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_timer_nxt = r_timer - 1'b1;
                end
            end

            ERROR: begin
                if (r_fail == c_fail_max) begin
                    // Too many failures: lockout wins over any press
                    w_state_nxt = LOCKOUT;
                    w_timer_nxt = c_lock_load;
                    w_led_nxt   = 1'b1;
                end else if (w_press) begin
                    w_state_nxt = IDLE;
                    w_led_nxt   = 1'b0;
                end else if (r_blink == '0) begin
                    w_led_nxt   = ~r_led;
                    w_blink_nxt = c_blink_load;
                end else begin
                    w_blink_nxt = r_blink - 1'b1;
                end
            end

            LOCKOUT: begin
                // Presses are ignored until the timer runs out
                if (r_timer == '0) begin
                    w_state_nxt = IDLE;
                    w_fail_nxt  = '0;
                    w_led_nxt   = 1'b0;
                end else begin
                    w_timer_nxt = r_timer - 1'b1;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register with registered, glitch-free indicator outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_match  <= 1'b1;
            r_timer  <= '0;
            r_blink  <= '0;
            r_fail   <= '0;
            r_open   <= 1'b0;
            r_error  <= 1'b0;
            r_led    <= 1'b0;
            r_locked <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_idx    <= w_idx_nxt;
            r_match  <= w_match_nxt;
            r_timer  <= w_timer_nxt;
            r_blink  <= w_blink_nxt;
            r_fail   <= w_fail_nxt;
            r_open   <= (w_state_nxt == OPEN);
            r_error  <= (w_state_nxt == ERROR);
            r_led    <= w_led_nxt;
            r_locked <= (w_state_nxt == LOCKOUT);
        end
    end

    assign open     = r_open;
    assign error    = r_error;
    assign led      = r_led;
    assign locked   = r_locked;
    assign fail_cnt = r_fail;

endmodule
`default_nettype wire

// File: tb/tb_combo_lock.sv
`default_nettype none
// ============================================================================
//  Module      : tb_combo_lock
//  Description : Self-checking bench for combo_lock. A deadline-based
//                reference model predicts every indicator each cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_combo_lock;

    localparam int KEY_W       = 2;
    localparam int CODE_LEN    = 2;
    localparam int MAX_FAIL    = 3;
    localparam int OPEN_CYCLES = 16;
    localparam int LOCK_CYCLES = 64;
    localparam int BLINK_HALF  = 4;
    localparam int FOREVER     = 32'h7fff_ffff;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       enter = 1'b0;
    logic [1:0] key   = 2'b00;
    logic       open, error, led, locked;
    logic [1:0] fail_cnt;
    logic [5:0] obs;

    assign obs = {open, error, led, locked, fail_cnt};

    always #5 clk = ~clk;

    combo_lock #(
        .KEY_W       (KEY_W),
        .CODE_LEN    (CODE_LEN),
        .CODE        (4'b10_01),
        .MAX_FAIL    (MAX_FAIL),
        .OPEN_CYCLES (OPEN_CYCLES),
        .LOCK_CYCLES (LOCK_CYCLES),
        .BLINK_HALF  (BLINK_HALF)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enter    (enter),
        .key      (key),
        .open     (open),
        .error    (error),
        .led      (led),
        .locked   (locked),
        .fail_cnt (fail_cnt)
    );

    int n_pass = 0;
    int n_chk  = 0;

    // ---------------- reference model (deadlines, not states) --------------
    logic [1:0] code_tab [2];
    int         mcyc = 0;
    int         open_end = 0, err_start = 0, err_end = 0;
    int         lock_start = 0, lock_end = 0, m_fail = 0;
    logic [1:0] entries [$];
    logic [3:0] hist = 4'b0;

    initial begin
        code_tab[0] = 2'b01;
        code_tab[1] = 2'b10;
    end

    // Model update at every rising edge; press = enter rose 3 edges ago
    always @(posedge clk) begin
        int  n;
        bit  p, po, pe, pl, ok;
        n  = mcyc + 1;
        p  = hist[2] & ~hist[3];
        po = (n - 1) < open_end;
        pe = (err_start <= n - 1) && (n - 1 < err_end);
        pl = (lock_start <= n - 1) && (n - 1 < lock_end);
        if (rst) begin
            open_end = n; err_start = n; err_end = n;
            lock_start = n; lock_end = n; m_fail = 0;
            entries.delete();
            hist = 4'b0;
        end else begin
            if (po) begin
                if (p) open_end = n;
            end else if (pe) begin
                if (m_fail == MAX_FAIL) begin
                    err_end = n; lock_start = n; lock_end = n + LOCK_CYCLES;
                end else if (p) begin
                    err_end = n;
                end
            end else if (pl) begin
                if (n == lock_end) m_fail = 0;
            end else if (p) begin
                entries.push_back(key);
                if (entries.size() == CODE_LEN) begin
                    ok = 1'b1;
                    foreach (entries[i]) if (entries[i] !== code_tab[i]) ok = 1'b0;
                    if (ok) begin
                        open_end = n + OPEN_CYCLES;
                        m_fail   = 0;
                    end else begin
                        m_fail    = (m_fail < MAX_FAIL) ? m_fail + 1 : MAX_FAIL;
                        err_start = n;
                        err_end   = FOREVER;
                    end
                    entries.delete();
                end
            end
            hist = {hist[2:0], enter};
        end
        mcyc = n;
    end

    function automatic logic [5:0] exp_bits();
        bit o, e, l, d;
        o = mcyc < open_end;
        e = (err_start <= mcyc) && (mcyc < err_end);
        l = (lock_start <= mcyc) && (mcyc < lock_end);
        d = l ? 1'b1 : (e ? (((mcyc - err_start) / BLINK_HALF) % 2 == 0) : 1'b0);
        return {o, e, d, l, 2'(m_fail)};
    endfunction

    // ---------------- stimulus plan (one entry per cycle) -------------------
    bit         pe_q [$];
    logic [1:0] pk_q [$];
    bit         pr_q [$];
    logic [1:0] last_key = 2'b00;

    function automatic void plan_press(logic [1:0] k, int hold, int gap);
        for (int j = 0; j < hold; j++) begin pe_q.push_back(1'b1); pk_q.push_back(k); pr_q.push_back(1'b0); end
        for (int j = 0; j < gap; j++)  begin pe_q.push_back(1'b0); pk_q.push_back(k); pr_q.push_back(1'b0); end
        last_key = k;
    endfunction

    function automatic void plan_idle(int n);
        for (int j = 0; j < n; j++) begin pe_q.push_back(1'b0); pk_q.push_back(last_key); pr_q.push_back(1'b0); end
    endfunction

    function automatic void plan_rst(int n);
        for (int j = 0; j < n; j++) begin pe_q.push_back(1'b0); pk_q.push_back(2'b00); pr_q.push_back(1'b1); end
        last_key = 2'b00;
    endfunction

    function automatic void plan_clear();
        pe_q.delete(); pk_q.delete(); pr_q.delete();
    endfunction

    // ---------------- tests -------------------------------------------------
    task automatic test_reset();
        plan_rst(10);
        plan_idle(3);
        foreach (pe_q[i]) begin
            @(negedge clk);
            n_chk++;
            if (obs !== exp_bits()) $display("FAIL reset_model cyc=%0d got=%b exp=%b", mcyc, obs, exp_bits());
            else n_pass++;
            if (i == 9) begin
                n_chk++;
                if (obs !== 6'b0) $display("FAIL reset_values got=%b exp=000000", obs);
                else n_pass++;
            end
            enter = pe_q[i]; key = pk_q[i]; rst = pr_q[i];
        end
        plan_clear();
    endtask

    task automatic test_open();
        int i2, first_open, open_cnt;
        first_open = -1; open_cnt = 0;
        plan_press(2'b01, 1, 4);
        i2 = pe_q.size();
        plan_press(2'b10, 1, 4);
        plan_idle(20);
        foreach (pe_q[i]) begin
            @(negedge clk);
            n_chk++;
            if (obs !== exp_bits()) $display("FAIL open_model cyc=%0d got=%b exp=%b", mcyc, obs, exp_bits());
            else n_pass++;
            if (open === 1'b1) begin
                open_cnt++;
                if (first_open < 0) first_open = i;
            end
            enter = pe_q[i]; key = pk_q[i]; rst = pr_q[i];
        end
        plan_clear();
        n_chk++;
        if (first_open != i2 + 4) $display("FAIL open_latency got=%0d exp=%0d", first_open, i2 + 4);
        else n_pass++;
        n_chk++;
        if (open_cnt != OPEN_CYCLES) $display("FAIL open_duration got=%0d exp=%0d", open_cnt, OPEN_CYCLES);
        else n_pass++;
        n_chk++;
        if (fail_cnt !== 2'd0) $display("FAIL open_failcnt got=%0d exp=0", fail_cnt);
        else n_pass++;
    endtask

    task automatic test_error();
        int i2, i3, e, bad;
        bad = 0;
        plan_press(2'b11, 1, 4);
        i2 = pe_q.size();
        plan_press(2'b11, 1, 14);
        i3 = pe_q.size();
        plan_press(2'b11, 1, 4);
        plan_idle(6);
        e = i2 + 4;
        foreach (pe_q[i]) begin
            @(negedge clk);
            n_chk++;
            if (obs !== exp_bits()) $display("FAIL error_model cyc=%0d got=%b exp=%b", mcyc, obs, exp_bits());
            else n_pass++;
            if (i == e) begin
                n_chk++;
                if (error !== 1'b1 || fail_cnt !== 2'd1) $display("FAIL error_entry got err=%b fc=%0d exp err=1 fc=1", error, fail_cnt);
                else n_pass++;
            end
            if (i >= e && i < e + 12 && led !== ((((i - e) / 4) % 2) == 0)) bad++;
            if (i == i3 + 4) begin
                n_chk++;
                if (error !== 1'b0 || led !== 1'b0) $display("FAIL error_clear got err=%b led=%b exp 0 0", error, led);
                else n_pass++;
            end
            enter = pe_q[i]; key = pk_q[i]; rst = pr_q[i];
        end
        plan_clear();
        n_chk++;
        if (bad != 0) $display("FAIL error_blink got=%0d bad cycles exp=0", bad);
        else n_pass++;
    endtask

    task automatic test_lockout();
        int lock_cnt, bad_led;
        bit seen;
        lock_cnt = 0; bad_led = 0; seen = 1'b0;
        plan_rst(2);
        plan_idle(2);
        for (int a = 0; a < 3; a++) begin
            plan_press(2'b00, 1, 4);
            plan_press(2'b11, 1, 4);
            if (a < 2) plan_press(2'b00, 1, 4);
        end
        for (int j = 0; j < 6; j++) plan_press(2'b01, 2, 6);
        plan_idle(40);
        foreach (pe_q[i]) begin
            @(negedge clk);
            n_chk++;
            if (obs !== exp_bits()) $display("FAIL lockout_model cyc=%0d got=%b exp=%b", mcyc, obs, exp_bits());
            else n_pass++;
            if (locked === 1'b1) begin
                lock_cnt++;
                if (led !== 1'b1 || error !== 1'b0) bad_led++;
                if (!seen) begin
                    seen = 1'b1;
                    n_chk++;
                    if (fail_cnt !== 2'd3) $display("FAIL lockout_failcnt got=%0d exp=3", fail_cnt);
                    else n_pass++;
                end
            end
            enter = pe_q[i]; key = pk_q[i]; rst = pr_q[i];
        end
        plan_clear();
        n_chk++;
        if (lock_cnt != LOCK_CYCLES) $display("FAIL lockout_duration got=%0d exp=%0d", lock_cnt, LOCK_CYCLES);
        else n_pass++;
        n_chk++;
        if (bad_led != 0) $display("FAIL lockout_led got=%0d bad cycles exp=0", bad_led);
        else n_pass++;
        n_chk++;
        if (locked !== 1'b0 || fail_cnt !== 2'd0) $display("FAIL lockout_exit got lk=%b fc=%0d exp 0 0", locked, fail_cnt);
        else n_pass++;
    endtask

    task automatic test_hold();
        int i2, first_open;
        first_open = -1;
        plan_press(2'b01, 100, 4);
        i2 = pe_q.size();
        plan_press(2'b10, 1, 4);
        plan_idle(20);
        foreach (pe_q[i]) begin
            @(negedge clk);
            n_chk++;
            if (obs !== exp_bits()) $display("FAIL hold_model cyc=%0d got=%b exp=%b", mcyc, obs, exp_bits());
            else n_pass++;
            if (open === 1'b1 && first_open < 0) first_open = i;
            enter = pe_q[i]; key = pk_q[i]; rst = pr_q[i];
        end
        plan_clear();
        n_chk++;
        if (first_open != i2 + 4) $display("FAIL hold_single_press got=%0d exp=%0d", first_open, i2 + 4);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int r1, r2;
        bit opened1, opened2;
        opened1 = 1'b0; opened2 = 1'b0;
        plan_press(2'b01, 1, 4);
        r1 = pe_q.size();
        plan_rst(1);
        plan_idle(2);
        plan_press(2'b01, 1, 4);
        plan_press(2'b10, 1, 4);
        plan_idle(20);
        for (int a = 0; a < 3; a++) begin
            plan_press(2'b11, 1, 4);
            plan_press(2'b11, 1, 4);
            if (a < 2) plan_press(2'b00, 1, 4);
        end
        plan_idle(10);
        r2 = pe_q.size();
        plan_rst(1);
        plan_idle(2);
        plan_press(2'b01, 1, 4);
        plan_press(2'b10, 1, 4);
        plan_idle(20);
        foreach (pe_q[i]) begin
            @(negedge clk);
            n_chk++;
            if (obs !== exp_bits()) $display("FAIL rstmid_model cyc=%0d got=%b exp=%b", mcyc, obs, exp_bits());
            else n_pass++;
            if (i == r1 + 1 || i == r2 + 1) begin
                n_chk++;
                if (obs !== 6'b0) $display("FAIL rstmid_values idx=%0d got=%b exp=000000", i, obs);
                else n_pass++;
            end
            if (i > r1 && i < r1 + 40 && open === 1'b1) opened1 = 1'b1;
            if (i > r2 && open === 1'b1) opened2 = 1'b1;
            enter = pe_q[i]; key = pk_q[i]; rst = pr_q[i];
        end
        plan_clear();
        n_chk++;
        if (opened1 !== 1'b1 || opened2 !== 1'b1) $display("FAIL rstmid_reopen got=%b%b exp=11", opened1, opened2);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int j = 0; j < 40; j++) begin
            logic [1:0] k;
            if ($urandom_range(0, 3) != 0) k = code_tab[j % 2];
            else k = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 24) == 0) plan_rst(1);
            plan_press(k, $urandom_range(1, 6), $urandom_range(3, 10));
        end
        plan_idle(80);
        foreach (pe_q[i]) begin
            @(negedge clk);
            n_chk++;
            if (obs !== exp_bits()) $display("FAIL random_model cyc=%0d got=%b exp=%b", mcyc, obs, exp_bits());
            else n_pass++;
            enter = pe_q[i]; key = pk_q[i]; rst = pr_q[i];
        end
        plan_clear();
    endtask

    initial begin
        test_reset();
        test_open();
        test_error();
        test_lockout();
        test_hold();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench did not finish in time");
    end

endmodule
`default_nettype wire

// File: doc/combo_lock.md
# combo_lock

Parametrised combination-lock controller, successor to the fixed two-key Moore lock with its enter synchroniser and error-blink LED. It accepts a code of CODE_LEN entries, each KEY_W bits wide, and samples one entry per debounced press of `enter`. It opens on a match, flags and blinks on a mismatch, and enforces a timed lockout after MAX_FAIL consecutive failures. It sits directly behind the board switches/buttons on the already-divided system clock and drives the OPEN/ERROR/LED indicators.

## Interface
- KEY_W, 2 — width of one code entry; entry = {keyB, keyA} in the default build
- CODE_LEN, 2 — number of entries per code attempt (≥1)
- CODE, 4'b10_01 — secret code, CODE_LEN*KEY_W bits; entry i at [i*KEY_W +: KEY_W], entry 0 entered first
- MAX_FAIL, 3 — consecutive failed attempts that trigger lockout (≥1)
- OPEN_CYCLES, 16 — cycles OPEN is held before auto-relock
- LOCK_CYCLES, 64 — lockout duration in cycles
- BLINK_HALF, 4 — LED half-period in ERROR, in cycles
- clk  in  1  system clock (post-divider)
- rst  in  1  synchronous reset; active-high
- enter  in  1  raw button, asynchronous to clk
- key  in  KEY_W  code entry; must be stable from enter rise until the entry is sampled
- open  out  1  lock open
- error  out  1  last attempt was wrong
- led  out  1  blink indicator
- locked  out  1  lockout active
- fail_cnt  out  $clog2(MAX_FAIL+1)  consecutive failures so far

## Operation
- Reset values: state IDLE; open=0, error=0, led=0, locked=0, fail_cnt=0; entry index=0; match flag=1; all timers=0.
- Press event: a rising edge of synchronised `enter` produces a one-cycle `press`. Holding enter high yields exactly one press.
- IDLE: each press compares `key` with CODE entry idx. The match flag is ANDed with the result, and idx increments.
  - The press that completes entry CODE_LEN-1 evaluates the attempt:
    - all entries matched → OPEN, fail_cnt=0
    - otherwise → ERROR, fail_cnt+1
  - idx resets to 0 and match resets to 1.
  - Wrong entries are not revealed early; all CODE_LEN entries are always collected.
- OPEN: open=1.
  - Leaves to IDLE after OPEN_CYCLES cycles, or on a press, whichever comes first.
  - A press in OPEN only closes the lock; it is not counted as a code entry.
- ERROR: error=1. led=1 on the entry cycle and toggles every BLINK_HALF cycles.
  - A press → IDLE (error=0, led=0); that press is not counted as an entry.
  - If fail_cnt==MAX_FAIL on entry to ERROR, the next cycle goes to LOCKOUT regardless of any press.
- LOCKOUT: locked=1, led=1 steady, error=0.
  - Presses are ignored.
  - After LOCK_CYCLES cycles → IDLE with fail_cnt=0.
- Simultaneous events:
  - A press on the last cycle of the OPEN timeout → IDLE; the press is consumed.
  - rst has priority over everything.
- Reset mid-operation (any state, including mid-code or LOCKOUT) returns to the reset values. No partial entry survives.
- The fail_cnt increment saturates at MAX_FAIL.

## Timing
- Synchroniser: two flops; the edge detector takes a third flop.
  - enter first sampled high at edge k → press high during cycle after edge k+2.
  - FSM acts at edge k+3.
- key is sampled at edge k+3, so it must be stable from edge k through k+3.
- Outputs are registered.
  - The entry completing the code → open/error high from edge k+3.
  - fail_cnt updates at the same edge.
- OPEN lasts exactly OPEN_CYCLES cycles with open=1 when no press occurs.
- LOCKOUT lasts exactly LOCK_CYCLES cycles with locked=1.
- Minimum spacing between counted presses: enter low for ≥2 cycles between presses.

## Structure
- Package combo_lock_pkg:
  - state_t enum {IDLE, OPEN, ERROR, LOCKOUT}
  - helper function for timer widths ($clog2 of max(OPEN_CYCLES, LOCK_CYCLES, BLINK_HALF))
- Sub-module enter_sync: 2-flop synchroniser plus rising-edge detector; ports clk, rst, enter → press.
- Top holds the FSM, entry index, match flag, one shared down-timer (reloaded per state), blink counter and fail counter.

## Test plan
- Reset held 10 cycles, all inputs 0 → open=error=led=locked=0, fail_cnt=0.
- Default params. key=01 press, then key=10 press → open=1 at edge k+3 of the 2nd press; open=0 exactly 16 cycles later; fail_cnt=0.
- key=11 press, key=11 press → error=1, fail_cnt=1, led toggles every 4 cycles. Next press → error=0, led=0, state IDLE.
- Three wrong attempts in a row → fail_cnt=3 and locked=1 for exactly 64 cycles, with led steady 1.
  - Presses during lockout have no effect.
  - Afterwards locked=0 and fail_cnt=0.
- Enter held high for 100 cycles with key=01, then correct entry 10 → one counted press only; lock opens after the 2nd press.
- rst asserted mid-code (after 1 entry) and mid-LOCKOUT → all outputs return to reset values the next cycle.
  - A following correct 2-entry code opens.
